// File: rtl/spi_pkg.sv
// Shared types and width helpers for the receive-only SPI master.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} spi_state_t;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: free-running half-period counter that toggles sclk while run is high.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter bit CPOL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic sclk,
  output logic tick,
  output logic lead_edge,
  output logic trail_edge
);

  localparam int DW = cnt_w(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  assign tick       = !clear && (div_cnt == DIV_LAST);
  // Leading edge moves sclk away from its idle level, trailing edge returns it.
  assign lead_edge  = tick && run && (sclk == CPOL);
  assign trail_edge = tick && run && (sclk != CPOL);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div_cnt <= '0;
      sclk    <= CPOL;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick && run) sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_rx_master.sv
// Receive-only SPI master: clocks FRAME_BITS bits in from miso, MSB first, in any CPOL/CPHA mode.
module spi_rx_master
  import spi_pkg::*;
#(
  parameter int FRAME_BITS   = 40,
  parameter int CLK_DIV      = 4,
  parameter bit CPOL         = 1'b0,
  parameter bit CPHA         = 1'b0,
  parameter int GAP_CYCLES   = 2,
  parameter bit AUTO_RESTART = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  ss_n,
  output logic [FRAME_BITS-1:0] dout,
  output logic                  dout_valid,
  output logic                  busy
);

  localparam int EW = cnt_w(2 * FRAME_BITS);
  localparam int GW = cnt_w(GAP_CYCLES - 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * FRAME_BITS);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  spi_state_t            state, state_next;
  logic [EW-1:0]         edge_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [FRAME_BITS-1:0] sr;
  logic                  run, clear, tick, lead_edge, trail_edge, sample, frame_done;

  // The divider keeps ticking after the last sclk edge so the trail time matches the lead time.
  assign run    = (state == SETUP) || ((state == SHIFT) && (edge_cnt != LAST_EDGE));
  assign clear  = (state == IDLE) || (state == GAP);
  assign sample = CPHA ? trail_edge : lead_edge;

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .clear      (clear),
    .sclk       (sclk),
    .tick       (tick),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    unique case (state)
      IDLE:  if (start || AUTO_RESTART) state_next = SETUP;
      SETUP: if (tick) state_next = SHIFT;
      SHIFT: if (tick && (edge_cnt == LAST_EDGE)) begin
               state_next = GAP;
               frame_done = 1'b1;
             end
      GAP:   if (gap_cnt == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output registers, loaded from the next state so ss_n/busy line up with the state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_n       <= 1'b1;
      busy       <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      ss_n       <= !((state_next == SETUP) || (state_next == SHIFT));
      busy       <= (state_next != IDLE);
      dout_valid <= frame_done;
      if (frame_done) dout <= sr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state == IDLE)) begin
      edge_cnt <= '0;
    end else if (tick && run) begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state != GAP)) gap_cnt <= '0;
    else                       gap_cnt <= gap_cnt + 1'b1;
  end

  // Shift register: data only, cleared on every pass through IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE)  sr <= '0;
    else if (sample)    sr <= FRAME_BITS'({sr, miso});
  end

endmodule

// File: tb/tb_spi_rx_master.sv
// Scoreboard bench: four 40-bit one-shot instances (modes 0..3) plus one 8-bit auto-restart instance.
module tb_spi_rx_master;

  typedef struct {
    logic [39:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- 40-bit instances, one per SPI mode ----------------
  logic        rst_m   = 1'b1;
  logic        start_m = 1'b0;
  logic        rst_mq  = 1'b1;
  logic [39:0] tx40    = '0;
  logic        miso_m  [4];
  logic        sclk_m  [4];
  logic        ss_m    [4];
  logic        dv_m    [4];
  logic        busy_m  [4];
  logic [39:0] dout_m  [4];

  always @(posedge clk) rst_mq <= rst_m;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam bit MCPOL = ((m / 2) == 1);
    localparam bit MCPHA = ((m % 2) == 1);

    spi_rx_master #(
      .FRAME_BITS   (40),
      .CLK_DIV      (2),
      .CPOL         (MCPOL),
      .CPHA         (MCPHA),
      .GAP_CYCLES   (2),
      .AUTO_RESTART (1'b0)
    ) dut (
      .clk        (clk),
      .rst        (rst_m),
      .start      (start_m),
      .miso       (miso_m[m]),
      .sclk       (sclk_m[m]),
      .ss_n       (ss_m[m]),
      .dout       (dout_m[m]),
      .dout_valid (dv_m[m]),
      .busy       (busy_m[m])
    );

    exp_t        q[$];
    int          e         = 0;
    int          low_len   = 0;
    logic        sclk_prev = MCPOL;
    logic [39:0] dout_prev = '0;

    // Slave: CPHA=0 presents bit 0 up front and shifts on trailing edges; CPHA=1 shifts on leading edges.
    always @(negedge clk) begin
      if (ss_m[m]) begin
        e = 0;
        miso_m[m] = MCPHA ? ~tx40[39] : tx40[39];
      end else if (sclk_m[m] != sclk_prev) begin
        e = e + 1;
        if (!MCPHA && (e % 2 == 0) && (e < 80)) miso_m[m] = tx40[39 - e / 2];
        if (MCPHA && (e % 2 == 1))              miso_m[m] = tx40[39 - (e - 1) / 2];
      end
      sclk_prev = sclk_m[m];
    end

    always @(negedge clk) begin
      exp_t x;
      if (dv_m[m]) begin
        chk($sformatf("m%0d_valid_expected", m), 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          x = q.pop_front();
          chk($sformatf("m%0d_dout", m), 64'(dout_m[m]), 64'(x.data));
          chk($sformatf("m%0d_valid_cycle", m), 64'(cyc), 64'(x.cyc));
          chk($sformatf("m%0d_ss_low_len", m), 64'(low_len), 64'd162);
          chk($sformatf("m%0d_ss_at_valid", m), 64'(ss_m[m]), 64'd1);
          chk($sformatf("m%0d_sclk_after", m), 64'(sclk_m[m]), 64'(MCPOL));
        end
      end
      if (!rst_mq && (dout_m[m] != dout_prev))
        chk($sformatf("m%0d_dout_change_has_valid", m), 64'(dv_m[m]), 64'd1);
      dout_prev = dout_m[m];
      if (ss_m[m]) low_len = 0;
      else         low_len = low_len + 1;
    end
  end

  // ---------------- 8-bit auto-restart instance ----------------
  logic       rst_a   = 1'b1;
  logic       rst_aq  = 1'b1;
  logic       start_a = 1'b0;
  logic       miso_a  = 1'b0;
  logic       sclk_a, ss_a, dv_a, busy_a;
  logic [7:0] dout_a;
  logic [7:0] tx8 [4];
  exp_t       qa[$];

  always @(posedge clk) rst_aq <= rst_a;

  spi_rx_master #(
    .FRAME_BITS   (8),
    .CLK_DIV      (1),
    .CPOL         (1'b0),
    .CPHA         (1'b0),
    .GAP_CYCLES   (2),
    .AUTO_RESTART (1'b1)
  ) dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .start      (start_a),
    .miso       (miso_a),
    .sclk       (sclk_a),
    .ss_n       (ss_a),
    .dout       (dout_a),
    .dout_valid (dv_a),
    .busy       (busy_a)
  );

  int         ea = 0;
  int         fa = 0;
  logic       ss_prev_a   = 1'b1;
  logic       sclk_prev_a = 1'b0;
  logic [7:0] cur_a;
  logic [7:0] dout_prev_a = '0;

  always @(negedge clk) begin
    if (rst_a) fa = 0;
    else if (ss_a && !ss_prev_a) fa = fa + 1;
    cur_a = (fa < 4) ? tx8[fa] : 8'h00;
    if (ss_a) begin
      ea = 0;
      miso_a = cur_a[7];
    end else if (sclk_a != sclk_prev_a) begin
      ea = ea + 1;
      if ((ea % 2 == 0) && (ea < 16)) miso_a = cur_a[7 - ea / 2];
    end
    ss_prev_a   = ss_a;
    sclk_prev_a = sclk_a;
  end

  always @(negedge clk) begin
    exp_t x;
    if (dv_a) begin
      chk("a8_valid_expected", 64'(qa.size() != 0), 64'd1);
      if (qa.size() != 0) begin
        x = qa.pop_front();
        chk("a8_dout", 64'(dout_a), 64'(x.data));
        chk("a8_valid_cycle", 64'(cyc), 64'(x.cyc));
      end
    end
    if (!rst_aq && (dout_a != dout_prev_a))
      chk("a8_dout_change_has_valid", 64'(dv_a), 64'd1);
    dout_prev_a = dout_a;
  end

  // ---------------- stimulus ----------------
  task automatic push_all(input logic [39:0] d, input int c);
    exp_t x;
    x.data = d;
    x.cyc  = c;
    g_mode[0].q.push_back(x);
    g_mode[1].q.push_back(x);
    g_mode[2].q.push_back(x);
    g_mode[3].q.push_back(x);
  endtask

  task automatic mode_frame(input logic [39:0] data, input bit completes, output int k);
    tx40 = data;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("m%0d_sclk_idle", i), 64'(sclk_m[i]), 64'(i / 2));
    start_m = 1'b1;
    k = cyc;
    if (completes) push_all(data, k + 163);
    @(negedge clk);
    start_m = 1'b0;
  endtask

  task automatic chk_busy(input logic exp, input string tag);
    for (int i = 0; i < 4; i++)
      chk($sformatf("m%0d_busy_%s", i, tag), 64'(busy_m[i]), 64'(exp));
  endtask

  initial begin
    int k;
    int c;
    tx8[0] = 8'h3C;
    tx8[1] = 8'hC3;
    tx8[2] = 8'hFF;
    tx8[3] = 8'h00;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("m%0d_rst_ss", i), 64'(ss_m[i]), 64'd1);
      chk($sformatf("m%0d_rst_sclk", i), 64'(sclk_m[i]), 64'(i / 2));
      chk($sformatf("m%0d_rst_dout", i), 64'(dout_m[i]), 64'd0);
      chk($sformatf("m%0d_rst_valid", i), 64'(dv_m[i]), 64'd0);
    end
    chk_busy(1'b0, "rst");
    rst_m = 1'b0;
    repeat (2) @(negedge clk);
    chk_busy(1'b0, "idle");

    // Basic frame in all four modes, with busy dropping after the two-cycle gap.
    mode_frame(40'hA5_1234_5678, 1'b1, k);
    repeat (163) @(negedge clk);
    chk_busy(1'b1, "gap");
    @(negedge clk);
    chk_busy(1'b0, "after_gap");
    repeat (10) @(negedge clk);

    // Reset around bit 20 of a frame: outputs return to idle, aborted data never shows.
    mode_frame(40'h12_3456_789A, 1'b0, k);
    repeat (84) @(negedge clk);
    rst_m = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("m%0d_abort_ss", i), 64'(ss_m[i]), 64'd1);
      chk($sformatf("m%0d_abort_dout", i), 64'(dout_m[i]), 64'd0);
      chk($sformatf("m%0d_abort_valid", i), 64'(dv_m[i]), 64'd0);
      chk($sformatf("m%0d_abort_sclk", i), 64'(sclk_m[i]), 64'(i / 2));
    end
    chk_busy(1'b0, "abort");
    rst_m = 1'b0;
    repeat (200) @(negedge clk);

    // Second start mid-frame is ignored: one frame, one valid.
    mode_frame(40'h0F_F00F_F05A, 1'b1, k);
    repeat (60) @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    while (cyc < k + 164) @(negedge clk);
    chk_busy(1'b1, "mid_gap");
    @(negedge clk);
    chk_busy(1'b0, "mid_after");
    repeat (200) @(negedge clk);
    chk_busy(1'b0, "mid_quiet");

    // All-ones then all-zeros; dout must hold through the gap.
    mode_frame(40'hFF_FFFF_FFFF, 1'b1, k);
    repeat (170) @(negedge clk);
    mode_frame(40'h00_0000_0000, 1'b1, k);
    repeat (170) @(negedge clk);

    chk("m0_queue_drained", 64'(g_mode[0].q.size()), 64'd0);
    chk("m1_queue_drained", 64'(g_mode[1].q.size()), 64'd0);
    chk("m2_queue_drained", 64'(g_mode[2].q.size()), 64'd0);
    chk("m3_queue_drained", 64'(g_mode[3].q.size()), 64'd0);

    // Auto-restart: frames every 1 + 1*17 + 2 = 20 cycles.
    chk("a8_rst_dout", 64'(dout_a), 64'd0);
    chk("a8_rst_ss", 64'(ss_a), 64'd1);
    chk("a8_rst_busy", 64'(busy_a), 64'd0);
    rst_a = 1'b0;
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      exp_t x;
      x.data = 40'(tx8[i]);
      x.cyc  = c + 18 + 20 * i;
      qa.push_back(x);
    end
    repeat (83) @(negedge clk);
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("a8_queue_drained", 64'(qa.size()), 64'd0);
    chk("a8_final_dout", 64'(dout_a), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
